// File: rtl/disp_refresh_ctrl_pkg.sv
// Shared definitions for the display refresh controller.
//   state_t : frame scheduler states
//   NSRC    : number of selectable display sources
//   HEX_W / BYTE_W : per-source slice widths of hex data and point/LES bytes
package disp_refresh_ctrl_pkg;

    localparam int unsigned NSRC   = 4;
    localparam int unsigned HEX_W  = 32;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_GAP
    } state_t;

endpackage

// File: rtl/disp_refresh_ctrl_if.sv
// Connection between the refresh scheduler and the seven-segment Display block.
//   master (scheduler): drives start/text/flash/hexs/point/les, reads seg_busy
//   slave  (Display)  : reads frame data, drives seg_busy
interface disp_refresh_ctrl_if;
    import disp_refresh_ctrl_pkg::*;

    logic              start;
    logic              text;
    logic              flash;
    logic [HEX_W-1:0]  hexs;
    logic [BYTE_W-1:0] point;
    logic [BYTE_W-1:0] les;
    logic              seg_busy;

    modport master (output start, text, flash, hexs, point, les, input seg_busy);
    modport slave  (input start, text, flash, hexs, point, les, output seg_busy);
endinterface

// File: rtl/disp_flash_div.sv
// Square-wave divider: flash toggles every FLASH_HALF clock cycles.
//   clk, rst (async, active-high) ; flash : divided square wave, reset low
module disp_flash_div #(
    parameter int unsigned FLASH_HALF = 25000000
) (
    input  logic clk,
    input  logic rst,
    output logic flash
);
    localparam int unsigned CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          flash_q, flash_d;

    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        flash_d = flash_q;
        if (cnt_q == CW'(FLASH_HALF - 1)) begin
            cnt_d   = '0;
            flash_d = ~flash_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            flash_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            flash_q <= flash_d;
        end
    end

    assign flash = flash_q;
endmodule

// File: rtl/disp_refresh_ctrl.sv
// Frame scheduler in front of the seven-segment Display block.
// Picks one of four sources (manual sel or auto page rotation), latches its
// frame data, pulses start, waits for the serializer, then holds an idle gap.
//   clk, rst (async, active-high)
//   en, auto, sel            : run enable, auto-rotate, manual source select
//   src_hexs/points/les/text : packed data of all four sources
//   disp (master)            : start/text/flash/hexs/point/les out, seg_busy in
//   cur_src, frame_done, tmo_err : status
module disp_refresh_ctrl
    import disp_refresh_ctrl_pkg::*;
#(
    parameter int unsigned FLASH_HALF  = 25000000,
    parameter int unsigned GAP_CYC     = 1024,
    parameter int unsigned PAGE_FRAMES = 64,
    parameter int unsigned BUSY_TMO    = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     auto,
    input  logic [1:0]               sel,
    input  logic [NSRC*HEX_W-1:0]    src_hexs,
    input  logic [NSRC*BYTE_W-1:0]   src_points,
    input  logic [NSRC*BYTE_W-1:0]   src_les,
    input  logic [NSRC-1:0]          src_text,
    disp_refresh_ctrl_if.master      disp,
    output logic [1:0]               cur_src,
    output logic                     frame_done,
    output logic                     tmo_err
);
    localparam int unsigned CNT_MAX = (GAP_CYC > BUSY_TMO) ? GAP_CYC : BUSY_TMO;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned FR_W    = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;        // shared by busy timeout and gap timing
    logic [FR_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [1:0]        page_src_q, page_src_d;
    logic [1:0]        cur_src_q, cur_src_d;
    logic              tmo_err_q, tmo_err_d;
    logic [HEX_W-1:0]  hexs_q, hexs_d;
    logic [BYTE_W-1:0] point_q, point_d;
    logic [BYTE_W-1:0] les_q, les_d;
    logic              text_q, text_d;
    logic [1:0]        sel_s1_q, sel_s2_q;  // sel comes from switches, unrelated to clk
    logic [1:0]        src;
    logic              start_c, frame_done_c;
    logic              flash_w;

    disp_flash_div #(.FLASH_HALF(FLASH_HALF)) u_flash (
        .clk   (clk),
        .rst   (rst),
        .flash (flash_w)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        frame_cnt_d  = frame_cnt_q;
        page_src_d   = page_src_q;
        cur_src_d    = cur_src_q;
        tmo_err_d    = tmo_err_q;
        hexs_d       = hexs_q;
        point_d      = point_q;
        les_d        = les_q;
        text_d       = text_q;
        start_c      = 1'b0;
        frame_done_c = 1'b0;
        src          = auto ? page_src_q : sel_s2_q;

        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                hexs_d    = src_hexs[src*HEX_W +: HEX_W];
                point_d   = src_points[src*BYTE_W +: BYTE_W];
                les_d     = src_les[src*BYTE_W +: BYTE_W];
                text_d    = src_text[src];
                cur_src_d = src;
                state_d   = ST_START;
            end
            ST_START: begin
                start_c = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (disp.seg_busy) begin
                    state_d = ST_WAIT_LO;
                end else if (cnt_q == CNT_W'(BUSY_TMO - 1)) begin
                    // Aborted frame: flagged, not counted toward page rotation.
                    tmo_err_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LO: begin
                if (!disp.seg_busy) begin
                    frame_done_c = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_GAP;
                    if (frame_cnt_q == FR_W'(PAGE_FRAMES - 1)) begin
                        frame_cnt_d = '0;
                        page_src_d  = page_src_q + 2'd1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FR_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = en ? ST_LOAD : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            page_src_q  <= '0;
            cur_src_q   <= '0;
            tmo_err_q   <= 1'b0;
            hexs_q      <= '0;
            point_q     <= '0;
            les_q       <= '0;
            text_q      <= 1'b1;
            sel_s1_q    <= '0;
            sel_s2_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            page_src_q  <= page_src_d;
            cur_src_q   <= cur_src_d;
            tmo_err_q   <= tmo_err_d;
            hexs_q      <= hexs_d;
            point_q     <= point_d;
            les_q       <= les_d;
            text_q      <= text_d;
            sel_s1_q    <= sel;
            sel_s2_q    <= sel_s1_q;
        end
    end

    // start is decoded from the state so an async reset removes it at once.
    assign disp.start = start_c;
    assign disp.text  = text_q;
    assign disp.flash = flash_w;
    assign disp.hexs  = hexs_q;
    assign disp.point = point_q;
    assign disp.les   = les_q;
    assign cur_src    = cur_src_q;
    assign frame_done = frame_done_c;
    assign tmo_err    = tmo_err_q;
endmodule

// File: tb/tb_disp_refresh_ctrl.sv
module tb_disp_refresh_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         auto = 1'b0;
    logic [1:0]   sel = 2'd0;
    logic [127:0] src_hexs;
    logic [31:0]  src_points;
    logic [31:0]  src_les;
    logic [3:0]   src_text;
    logic [1:0]   cur_src;
    logic         frame_done;
    logic         tmo_err;

    int npass = 0;
    int nfail = 0;
    int nchk  = 0;

    disp_refresh_ctrl_if disp ();

    disp_refresh_ctrl #(
        .FLASH_HALF  (4),
        .GAP_CYC     (8),
        .PAGE_FRAMES (2),
        .BUSY_TMO    (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .auto       (auto),
        .sel        (sel),
        .src_hexs   (src_hexs),
        .src_points (src_points),
        .src_les    (src_les),
        .src_text   (src_text),
        .disp       (disp),
        .cur_src    (cur_src),
        .frame_done (frame_done),
        .tmo_err    (tmo_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nchk = nchk + 1;
        assert (obs === exp_v) npass = npass + 1;
        else begin
            nfail = nfail + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (disp.start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(tag, disp.start, 1);
    endtask

    // Responsive serializer: goes busy one cycle after start for 4 cycles.
    task automatic run_frame(input logic [1:0] exp_src, input string tag);
        logic [31:0] exp_hex;
        wait_start({tag, "_start"});
        exp_hex = src_hexs[32*exp_src +: 32];
        check({tag, "_cur_src"}, cur_src, exp_src);
        check({tag, "_hexs"}, disp.hexs, exp_hex);
        tick();
        disp.seg_busy = 1'b1;
        repeat (4) tick();
        disp.seg_busy = 1'b0;
        #1;
        check({tag, "_frame_done"}, frame_done, 1);
        tick();
    endtask

    initial begin
        logic       saw;
        logic [1:0] exp_seq [9];
        exp_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

        src_hexs      = {32'h33333333, 32'h12345678, 32'hCAFEF00D, 32'h11110000};
        src_points    = {8'h77, 8'hA5, 8'h3C, 8'h01};
        src_les       = {8'h88, 8'h0F, 8'hF0, 8'h10};
        src_text      = 4'b0011;
        disp.seg_busy = 1'b0;
        sel           = 2'd2;

        // ---- reset values ----
        #2 rst = 1'b1;
        tick();
        check("rst_start", disp.start, 0);
        check("rst_text", disp.text, 1);
        check("rst_flash", disp.flash, 0);
        check("rst_hexs", disp.hexs, 0);
        check("rst_point", disp.point, 0);
        check("rst_les", disp.les, 0);
        check("rst_cur_src", cur_src, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_tmo_err", tmo_err, 0);
        rst = 1'b0;

        // ---- flash toggles every 4 clocks with en=0 ----
        repeat (3) tick();
        check("flash_hold0", disp.flash, 0);
        tick();
        check("flash_rise", disp.flash, 1);
        repeat (3) tick();
        check("flash_hold1", disp.flash, 1);
        tick();
        check("flash_fall", disp.flash, 0);
        check("idle_no_start", disp.start, 0);

        // ---- manual frame from source 2 ----
        en = 1'b1;
        tick();
        check("load_no_start", disp.start, 0);
        tick();
        check("man_start", disp.start, 1);
        check("man_hexs", disp.hexs, 32'h12345678);
        check("man_point", disp.point, 8'hA5);
        check("man_les", disp.les, 8'h0F);
        check("man_text", disp.text, 0);
        check("man_cur_src", cur_src, 2);
        tick();
        check("start_one_cycle", disp.start, 0);
        disp.seg_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                sel = 2'd1;
                src_hexs[95:64] = 32'hDEADBEEF;
            end
            tick();
        end
        check("mid_hexs_stable", disp.hexs, 32'h12345678);
        check("mid_cur_src_stable", cur_src, 2);
        check("mid_no_done", frame_done, 0);
        disp.seg_busy = 1'b0;
        #1;
        check("man_frame_done", frame_done, 1);
        tick();
        check("done_one_cycle", frame_done, 0);
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            saw = saw | disp.start;
        end
        check("gap_no_start", saw, 0);
        check("gap_hexs_stable", disp.hexs, 32'h12345678);
        tick();
        check("next_start", disp.start, 1);
        check("next_cur_src", cur_src, 1);
        check("next_hexs", disp.hexs, 32'hCAFEF00D);
        check("next_point", disp.point, 8'h3C);
        check("next_text", disp.text, 1);

        // ---- en dropped during WAIT_LO: no further frame ----
        tick();
        disp.seg_busy = 1'b1;
        tick();
        en = 1'b0;
        repeat (3) tick();
        disp.seg_busy = 1'b0;
        #1;
        check("endrop_done", frame_done, 1);
        tick();
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            saw = saw | disp.start;
        end
        check("endrop_no_start", saw, 0);

        // ---- auto rotation from a clean reset ----
        rst  = 1'b1;
        en   = 1'b1;
        auto = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            run_frame(exp_seq[i], $sformatf("auto%0d", i));
        end

        // ---- busy timeout: flagged, not counted ----
        wait_start("tmo_start");
        check("tmo_cur_src", cur_src, 0);
        repeat (3) tick();
        check("tmo_not_yet", tmo_err, 0);
        repeat (3) tick();
        check("tmo_set", tmo_err, 1);
        run_frame(2'd0, "after_tmo");
        check("tmo_sticky", tmo_err, 1);

        // ---- async reset while start is high ----
        wait_start("rst_mid_start");
        check("rst_mid_cur_src", cur_src, 1);
        check("rst_mid_tmo_pre", tmo_err, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_start_drop", disp.start, 0);
        check("rst_mid_tmo_clr", tmo_err, 0);
        check("rst_mid_cur_src0", cur_src, 0);
        check("rst_mid_hexs0", disp.hexs, 0);
        check("rst_mid_text1", disp.text, 1);
        tick();
        rst = 1'b0;
        en  = 1'b0;
        tick();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
